// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache line fill sequencer.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN,
    ACK
  } fill_state_t;

  localparam int unsigned LINE_W        = 256;
  localparam int unsigned LINE_OFS_BITS = 5;
  localparam int unsigned DEF_BEATS     = 4;
  localparam int unsigned BEAT_CNT_W    = $clog2(DEF_BEATS);

  localparam logic [31:0] LINE_OFS_MASK = (32'd1 << LINE_OFS_BITS) - 32'd1;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~LINE_OFS_MASK;
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_line_assembler.sv
// Beat counter and line buffer: writes each stored beat into its slot of the line,
// lowest address first, and flags the final beat of a line.
module ic_line_assembler
  import icache_pkg::*;
#(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = DEF_BEATS,
  parameter int unsigned CNT_W  = BEAT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              store_en,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              last_beat
);

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // The buffer is never cleared between fills, so the previous line stays visible
  // until the next fill overwrites it beat by beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      line     <= '0;
    end else begin
      if (clr) begin
        beat_cnt <= '0;
      end else if (wr_en) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (store_en) begin
        line[beat_cnt*BEAT_W +: BEAT_W] <= beat_data;
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Miss/fill sequencer for the 16 x 32 B direct-mapped I-cache.
// Optional feature: define ICFILL_TIMEOUT_EN for the bus idle timeout and fill_err.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned BEAT_W      = 64,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_miss,
  input  logic [31:0]       ic_miss_addr,
  input  logic              ic_exp,
  output logic [LINE_W-1:0] ic_fill_data,
  output logic              ic_miss_ack,
  output logic              bus_req,
  output logic [31:0]       bus_addr,
  input  logic              bus_gnt,
  input  logic              bus_rd_valid,
  input  logic [BEAT_W-1:0] bus_rd_data,
  output logic              fill_busy,
  output logic              fill_err
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((BEAT_W * BEATS != LINE_W) || (TIMEOUT_CYC > 255)) begin : g_bad_cfg
    $error("icache_fill_ctrl: BEAT_W*BEATS must be 256 and TIMEOUT_CYC <= 255");
  end

  fill_state_t        state, state_nxt;
  logic [31:0]        addr_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic               last_beat;
  logic               asm_clr, asm_wr, asm_store;
  logic               timeout_hit;

  assign asm_clr   = (state == REQ) && bus_gnt;
  assign asm_wr    = ((state == DATA) || (state == DRAIN)) && bus_rd_valid;
  assign asm_store = (state == DATA) && bus_rd_valid && !ic_exp;

  ic_line_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .wr_en     (asm_wr),
    .store_en  (asm_store),
    .beat_data (bus_rd_data),
    .line      (ic_fill_data),
    .beat_cnt  (beat_cnt),
    .last_beat (last_beat)
  );

`ifdef ICFILL_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       in_bus_phase;

  assign in_bus_phase = (state == REQ) || (state == DATA) || (state == DRAIN);
  assign timeout_hit  = in_bus_phase && (idle_cnt == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_bus_phase || bus_gnt || bus_rd_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if ((state == IDLE) && ic_miss && !ic_exp) begin
      addr_q <= line_align(ic_miss_addr);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (ic_miss && !ic_exp) state_nxt = REQ;
      REQ: begin
        if (bus_gnt)     state_nxt = ic_exp ? DRAIN : DATA;
        else if (ic_exp) state_nxt = IDLE;
      end
      DATA: begin
        // An abort on the final beat has nothing left to drain.
        if (bus_rd_valid && last_beat) state_nxt = ic_exp ? IDLE : ACK;
        else if (ic_exp)               state_nxt = DRAIN;
      end
      DRAIN: if (bus_rd_valid && last_beat) state_nxt = IDLE;
      ACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  always_comb begin
    bus_req     = 1'b0;
    bus_addr    = '0;
    ic_miss_ack = 1'b0;
    fill_busy   = (state != IDLE);
    fill_err    = timeout_hit;
    if (state == REQ) begin
      bus_req  = 1'b1;
      bus_addr = addr_q;
    end
    if (state == ACK) ic_miss_ack = 1'b1;
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with hand-computed expected lines and cycle timing.
module tb_icache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_miss;
  logic [31:0]  ic_miss_addr;
  logic         ic_exp;
  logic [255:0] ic_fill_data;
  logic         ic_miss_ack;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_gnt;
  logic         bus_rd_valid;
  logic [63:0]  bus_rd_data;
  logic         fill_busy;
  logic         fill_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_ack  = 0;

  always #5 clk = ~clk;

  icache_fill_ctrl #(
    .BEAT_W      (64),
    .BEATS       (4),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_miss      (ic_miss),
    .ic_miss_addr (ic_miss_addr),
    .ic_exp       (ic_exp),
    .ic_fill_data (ic_fill_data),
    .ic_miss_ack  (ic_miss_ack),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_gnt      (bus_gnt),
    .bus_rd_valid (bus_rd_valid),
    .bus_rd_data  (bus_rd_data),
    .fill_busy    (fill_busy),
    .fill_err     (fill_err)
  );

  always @(posedge clk) if (rst_n && ic_miss_ack) n_ack++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    bus_rd_valid = 1'b1;
    bus_rd_data  = d;
    step();
    bus_rd_valid = 1'b0;
    bus_rd_data  = '0;
  endtask

  task automatic miss_and_grant(input logic [31:0] a, input logic [31:0] exp_addr, input string tag);
    ic_miss      = 1'b1;
    ic_miss_addr = a;
    step();
    ic_miss = 1'b0;
    check({tag, "_req"}, 256'(bus_req), 256'(1));
    check({tag, "_addr"}, 256'(bus_addr), 256'(exp_addr));
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
  endtask

  localparam logic [63:0] D11 = 64'h1111_1111_1111_1111, D22 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D33 = 64'h3333_3333_3333_3333, D44 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] E1 = 64'hE1E1_0000_0000_0001, E2 = 64'hE2E2_0000_0000_0002;
  localparam logic [63:0] E3 = 64'hE3E3_0000_0000_0003, E4 = 64'hE4E4_0000_0000_0004;
  localparam logic [63:0] A1 = 64'hA1A1_A1A1_0000_0001, A2 = 64'hA2A2_A2A2_0000_0002;
  localparam logic [63:0] A3 = 64'hA3A3_A3A3_0000_0003, A4 = 64'hA4A4_A4A4_0000_0004;
  localparam logic [63:0] B1 = 64'hB1B1_0000_1111_0001, B2 = 64'hB2B2_0000_2222_0002;
  localparam logic [63:0] B3 = 64'hB3B3_0000_3333_0003, B4 = 64'hB4B4_0000_4444_0004;
  localparam logic [63:0] C1 = 64'hC1C1_C1C1_C1C1_C1C1, C2 = 64'hC2C2_C2C2_C2C2_C2C2;
  localparam logic [63:0] C3 = 64'hC3C3_C3C3_C3C3_C3C3;
  localparam logic [63:0] F1 = 64'hF1F1_0123_4567_89AB, F2 = 64'hF2F2_0123_4567_89AB;
  localparam logic [63:0] F3 = 64'hF3F3_0123_4567_89AB, F4 = 64'hF4F4_0123_4567_89AB;

  initial begin
    rst_n        = 1'b0;
    ic_miss      = 1'b0;
    ic_miss_addr = '0;
    ic_exp       = 1'b0;
    bus_gnt      = 1'b0;
    bus_rd_valid = 1'b0;
    bus_rd_data  = '0;
    #23;
    check("rst_busy", 256'(fill_busy), 256'(0));
    check("rst_req", 256'(bus_req), 256'(0));
    check("rst_addr", 256'(bus_addr), 256'(0));
    check("rst_ack", 256'(ic_miss_ack), 256'(0));
    check("rst_data", ic_fill_data, 256'(0));
    check("rst_err", 256'(fill_err), 256'(0));
    rst_n = 1'b1;
    step();

    // 1: minimum-latency fill, ack in cycle 6
    check("t1_idle", 256'(fill_busy), 256'(0));
    miss_and_grant(32'h0000_1A40, 32'h0000_1A40, "t1");
    check("t1_busy", 256'(fill_busy), 256'(1));
    beat(D11); beat(D22); beat(D33);
    check("t1_noack", 256'(ic_miss_ack), 256'(0));
    beat(D44);
    check("t1_ack", 256'(ic_miss_ack), 256'(1));
    check("t1_data", ic_fill_data, {D44, D33, D22, D11});
    step();
    check("t1_ack_end", 256'(ic_miss_ack), 256'(0));
    check("t1_idle_end", 256'(fill_busy), 256'(0));
    check("t1_hold", ic_fill_data, {D44, D33, D22, D11});

    // 2: unaligned address, delayed grant, stray valid in REQ, gap after beat 2
    ic_miss      = 1'b1;
    ic_miss_addr = 32'h0000_01FF;
    step();
    ic_miss = 1'b0;
    check("t2_addr", 256'(bus_addr), 256'(32'h0000_01E0));
    bus_rd_valid = 1'b1;
    bus_rd_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus_rd_valid = 1'b0;
    step();
    check("t2_req_wait", 256'(bus_req), 256'(1));
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("t2_req_drop", 256'(bus_req), 256'(0));
    beat(E1); beat(E2);
    step();
    beat(E3);
    check("t2_noack", 256'(ic_miss_ack), 256'(0));
    beat(E4);
    check("t2_ack", 256'(ic_miss_ack), 256'(1));
    check("t2_data", ic_fill_data, {E4, E3, E2, E1});
    step();
    check("t2_ack_once", 256'(ic_miss_ack), 256'(0));

    // 3: abort after beat 2, remaining beats drained without storing
    miss_and_grant(32'h0000_2000, 32'h0000_2000, "t3");
    beat(A1); beat(A2);
    ic_exp = 1'b1;
    step();
    ic_exp = 1'b0;
    check("t3_drain_busy", 256'(fill_busy), 256'(1));
    beat(A3);
    check("t3_drain_noack", 256'(ic_miss_ack), 256'(0));
    beat(A4);
    check("t3_idle", 256'(fill_busy), 256'(0));
    check("t3_noack", 256'(ic_miss_ack), 256'(0));
    check("t3_data", ic_fill_data, {E4, E3, A2, A1});

    // 4: abort in REQ before grant, then an immediate new miss
    ic_miss      = 1'b1;
    ic_miss_addr = 32'h0000_3000;
    step();
    ic_miss = 1'b0;
    check("t4_req", 256'(bus_req), 256'(1));
    ic_exp = 1'b1;
    step();
    ic_exp = 1'b0;
    check("t4_req_drop", 256'(bus_req), 256'(0));
    check("t4_idle", 256'(fill_busy), 256'(0));
    miss_and_grant(32'h0000_3447, 32'h0000_3440, "t4b");
    beat(B1); beat(B2); beat(B3); beat(B4);
    check("t4_ack", 256'(ic_miss_ack), 256'(1));
    check("t4_data", ic_fill_data, {B4, B3, B2, B1});
    step();

    // 5: asynchronous reset during beat 3
    miss_and_grant(32'h0000_4000, 32'h0000_4000, "t5");
    beat(C1); beat(C2);
    bus_rd_valid = 1'b1;
    bus_rd_data  = C3;
    rst_n        = 1'b0;
    #1;
    check("t5_rst_busy", 256'(fill_busy), 256'(0));
    check("t5_rst_req", 256'(bus_req), 256'(0));
    check("t5_rst_ack", 256'(ic_miss_ack), 256'(0));
    check("t5_rst_data", ic_fill_data, 256'(0));
    bus_rd_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    miss_and_grant(32'h0000_5020, 32'h0000_5020, "t5b");
    beat(F1); beat(F2); beat(F3); beat(F4);
    check("t5_ack", 256'(ic_miss_ack), 256'(1));
    check("t5_data", ic_fill_data, {F4, F3, F2, F1});
    step();
    check("t5_idle", 256'(fill_busy), 256'(0));

`ifdef ICFILL_TIMEOUT_EN
    // 6: grant never arrives
    ic_miss      = 1'b1;
    ic_miss_addr = 32'h0000_6000;
    step();
    ic_miss = 1'b0;
    repeat (254) step();
    check("t6_pre_err", 256'(fill_err), 256'(0));
    check("t6_pre_req", 256'(bus_req), 256'(1));
    step();
    check("t6_err", 256'(fill_err), 256'(1));
    check("t6_noack", 256'(ic_miss_ack), 256'(0));
    step();
    check("t6_err_once", 256'(fill_err), 256'(0));
    check("t6_idle", 256'(fill_busy), 256'(0));
`else
    check("no_err", 256'(fill_err), 256'(0));
`endif

    step();
    check("ack_total", 256'(n_ack), 256'(4));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
